// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the register file: round-robin arbitration
// between two requesters plus a clear sequencer for x1..x(NREGS-1).
module regfile_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    output logic              r1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(NREGS);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_ptr;
    logic              rr_ptr;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic              g_ok;

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    // Grant mux: the winner's address/data, and whether it targets a real register.
    always_comb begin
        g_addr = gnt1 ? r1_addr : r0_addr;
        g_data = gnt1 ? r1_data : r0_data;
        g_ok   = (g_addr != '0) && ({1'b0, g_addr} < LIMIT);
    end

    // Next state and grants; a clear request beats both requesters.
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_ptr == LAST) state_nx = RUN;
            end
            RUN: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                end else if (r0_valid && r1_valid) begin
                    gnt0 = ~rr_ptr;
                    gnt1 = rr_ptr;
                end else begin
                    gnt0 = r0_valid;
                    gnt1 = r1_valid;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= CLEAR;
        else        state <= state_nx;
    end

    // Clear pointer, round-robin pointer and registered regfile write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_ptr   <= ADDR_W'(1);
            rr_ptr    <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
        end else begin
            rf_we     <= 1'b0;
            init_done <= (state == RUN) && !clr_req;
            if (state == CLEAR) begin
                rf_we    <= 1'b1;
                rf_waddr <= clr_ptr;
                rf_wdata <= '0;
                clr_ptr  <= clr_ptr + 1'b1;
            end else if (clr_req) begin
                clr_ptr <= ADDR_W'(1);
            end else if (gnt0 || gnt1) begin
                rf_we    <= g_ok;
                rf_waddr <= g_addr;
                rf_wdata <= g_data;
                rr_ptr   <= gnt0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter: a reference model predicts grants
// and the stream of regfile writes, a monitor compares what appears on rf_*.
module tb_regfile_wr_arbiter;

    localparam int DATA_W = 8;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;
    localparam int NCYC   = 3000;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                due;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr_req;
    logic              r0_valid;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_data;
    logic              r0_ready;
    logic              r1_valid;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data;
    logic              r1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              init_done;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    wr_t exp_q[$];

    // model state
    int                clr_left;
    int                pref;
    logic              init_exp;
    logic              pend0, pend1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    logic              g0, g1;

    regfile_wr_arbiter #(
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .r0_valid (r0_valid),
        .r0_addr  (r0_addr),
        .r0_data  (r0_data),
        .r0_ready (r0_ready),
        .r1_valid (r1_valid),
        .r1_addr  (r1_addr),
        .r1_data  (r1_data),
        .r1_ready (r1_ready),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void push_wr(input int addr, input int data);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = DATA_W'(data);
        e.due  = cyc;
        exp_q.push_back(e);
    endfunction

    // Reference model: one step per clock edge, from the rules of the block.
    task automatic model_edge();
        if (!rst_n) begin
            clr_left = NREGS - 1;
            pref     = 0;
            init_exp = 1'b0;
        end else if (clr_left > 0) begin
            push_wr(NREGS - clr_left, 0);
            clr_left--;
            init_exp = 1'b0;
        end else if (clr_req) begin
            clr_left = NREGS - 1;
            init_exp = 1'b0;
        end else begin
            init_exp = 1'b1;
            if (g0) begin
                if (a0 != 0 && int'(a0) < NREGS) push_wr(int'(a0), int'(d0));
                pend0 = 1'b0;
                pref  = 1;
            end else if (g1) begin
                if (a1 != 0 && int'(a1) < NREGS) push_wr(int'(a1), int'(d1));
                pend1 = 1'b0;
                pref  = 0;
            end
        end
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(0, NREGS - 1));
        if ($urandom_range(0, 7) == 0) a = '0;
        return a;
    endfunction

    // Monitor: every regfile write must match the oldest expected one, on time.
    always @(negedge clk) begin
        wr_t e;
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write cycle=%0d actual=x%0d/%0h required=none",
                         cyc, rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(rf_waddr), int'(e.addr));
                chk("wr_data", int'(rf_wdata), int'(e.data));
                chk("wr_cycle", cyc, e.due);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_write cycle=%0d actual=none required=x%0d/%0h",
                     cyc, e.addr, e.data);
        end
    end

    // Stimulus: random requests held until granted, rare clear requests,
    // and a reset pulse in the middle of the power-on clear.
    initial begin
        rst_n    = 1'b0;
        clr_req  = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        r0_addr  = '0;
        r1_addr  = '0;
        r0_data  = '0;
        r1_data  = '0;
        pend0    = 1'b0;
        pend1    = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        g0 = 1'b0; g1 = 1'b0;
        clr_left = NREGS - 1;
        pref     = 0;
        init_exp = 1'b0;
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            cyc++;
            model_edge();
            #1;
            rst_n = (cyc != 10);
            if (n < NCYC - 60) begin
                if (!pend0 && $urandom_range(0, 9) < 6) begin
                    pend0 = 1'b1;
                    a0    = rnd_addr();
                    d0    = DATA_W'($urandom);
                end
                if (!pend1 && $urandom_range(0, 9) < 6) begin
                    pend1 = 1'b1;
                    a1    = rnd_addr();
                    d1    = DATA_W'($urandom);
                end
                clr_req = rst_n && ($urandom_range(0, 99) == 0);
            end else begin
                clr_req = 1'b0;
            end
            r0_valid = pend0 && rst_n;
            r1_valid = pend1 && rst_n;
            r0_addr  = a0;
            r0_data  = d0;
            r1_addr  = a1;
            r1_data  = d1;
            #1;
            g0 = 1'b0;
            g1 = 1'b0;
            if (clr_left == 0 && !clr_req) begin
                if (r0_valid && r1_valid) begin
                    g0 = (pref == 0);
                    g1 = (pref == 1);
                end else begin
                    g0 = r0_valid;
                    g1 = r1_valid;
                end
            end
            chk("r0_ready", int'(r0_ready), int'(g0));
            chk("r1_ready", int'(r1_ready), int'(g1));
            chk("init_done", int'(init_done), int'(init_exp));
            if (cyc == 1 || cyc == 11) begin
                chk("rst_we", int'(rf_we), 0);
                chk("rst_waddr", int'(rf_waddr), 0);
                chk("rst_wdata", int'(rf_wdata), 0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
